// File: rtl/spi_slave_if.sv
// SPI slave bundle: host-side word handshake, mode bits and the four SPI pins.
// The slave modport is the core's view; master is the host/bench view.
interface spi_slave_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  cpol;
   logic                  cpha;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  tx_underrun;
   logic                  busy;
   logic                  sclk_pin;
   logic                  ncs_pin;
   logic                  mosi_pin;
   logic                  miso_pin;
   logic                  miso_oe;

   modport slave (
      input  cpol, cpha, tx_data, tx_valid, sclk_pin, ncs_pin, mosi_pin,
      output tx_ready, rx_data, rx_valid, tx_underrun, busy, miso_pin, miso_oe
   );

   modport master (
      output cpol, cpha, tx_data, tx_valid, sclk_pin, ncs_pin, mosi_pin,
      input  tx_ready, rx_data, rx_valid, tx_underrun, busy, miso_pin, miso_oe
   );
endinterface

// File: rtl/spi_slave.sv
// SPI slave for all four CPOL/CPHA modes; pins are resampled onto clk and
// a one-word holding register feeds the TX shifter for gapless streaming.
//
// state | meaning
// IDLE  | chip-select inactive, SCLK ignored, MISO released
// LOAD  | one cycle after ncs fall: holding word moved to TX shifter
// SHIFT | bits moving; words wrap and reload until ncs rises
module spi_slave #(
   parameter int DATA_WIDTH = 8,
   parameter bit MSB_FIRST  = 1'b1
) (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);
   localparam int            CW       = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t state, state_next;

   logic sclk_meta, sclk_sync, sclk_d;
   logic ncs_meta, ncs_sync, ncs_d;
   logic mosi_meta, mosi_sync;
   logic [1:0] settle_cnt;
   logic ncs_armed;

   logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;
   logic lead_edge, trail_edge, sample_edge, drive_edge;
   logic do_load, do_sample, do_drive, do_abort;

   logic [DATA_WIDTH-1:0] hold_reg, tx_sr, rx_sr;
   logic                  hold_valid;
   logic [CW-1:0]         bit_cnt;
   logic                  reload_pend, keep_bit, underrun_pend;
   logic [DATA_WIDTH-1:0] rx_data_r;
   logic                  rx_valid_r, underrun_r, miso_r, oe_r;

   logic [DATA_WIDTH-1:0] load_word, tx_adv, rx_next;
   logic                  take_hold, capture;

   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
   endfunction

   // The armed flag blocks a transfer already in flight when reset is released:
   // ncs must be seen high on real samples before a fall can start a word.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_meta  <= 1'b0;
         sclk_sync  <= 1'b0;
         sclk_d     <= 1'b0;
         ncs_meta   <= 1'b1;
         ncs_sync   <= 1'b1;
         ncs_d      <= 1'b1;
         mosi_meta  <= 1'b0;
         mosi_sync  <= 1'b0;
         settle_cnt <= 2'd3;
         ncs_armed  <= 1'b0;
      end else begin
         sclk_meta <= bus.sclk_pin;
         sclk_sync <= sclk_meta;
         sclk_d    <= sclk_sync;
         ncs_meta  <= bus.ncs_pin;
         ncs_sync  <= ncs_meta;
         ncs_d     <= ncs_sync;
         mosi_meta <= bus.mosi_pin;
         mosi_sync <= mosi_meta;
         if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;
         else if (ncs_sync)      ncs_armed  <= 1'b1;
      end
   end

   assign sclk_rise   = sclk_sync & ~sclk_d;
   assign sclk_fall   = ~sclk_sync & sclk_d;
   assign ncs_fall    = ncs_armed & ncs_d & ~ncs_sync;
   assign ncs_rise    = ~ncs_d & ncs_sync;
   assign lead_edge   = bus.cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = bus.cpol ? sclk_rise : sclk_fall;
   assign sample_edge = bus.cpha ? trail_edge : lead_edge;
   assign drive_edge  = bus.cpha ? lead_edge : trail_edge;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_load    = 1'b0;
      do_sample  = 1'b0;
      do_drive   = 1'b0;
      do_abort   = 1'b0;
      case (state)
         IDLE:    if (ncs_fall) state_next = LOAD;
         LOAD: begin
            state_next = SHIFT;
            do_load    = 1'b1;
         end
         SHIFT: begin
            do_sample = sample_edge;
            do_drive  = drive_edge;
         end
         default: state_next = IDLE;
      endcase
      if (ncs_rise && state != IDLE) begin
         state_next = IDLE;
         do_load    = 1'b0;
         do_sample  = 1'b0;
         do_drive   = 1'b0;
         do_abort   = 1'b1;
      end
   end

   assign load_word = hold_valid ? hold_reg : '0;
   assign take_hold = hold_valid & (do_load | (do_drive & reload_pend));
   assign capture   = bus.tx_valid & ~hold_valid;
   assign tx_adv    = MSB_FIRST ? {tx_sr[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, tx_sr[DATA_WIDTH-1:1]};
   assign rx_next   = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_sync}
                                : {mosi_sync, rx_sr[DATA_WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_reg      <= '0;
         hold_valid    <= 1'b0;
         tx_sr         <= '0;
         rx_sr         <= '0;
         bit_cnt       <= '0;
         reload_pend   <= 1'b0;
         keep_bit      <= 1'b0;
         underrun_pend <= 1'b0;
         rx_data_r     <= '0;
         rx_valid_r    <= 1'b0;
         underrun_r    <= 1'b0;
         miso_r        <= 1'b0;
         oe_r          <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         underrun_r <= 1'b0;

         if (take_hold) hold_valid <= 1'b0;
         if (capture) begin
            hold_reg   <= bus.tx_data;
            hold_valid <= 1'b1;
         end

         if (do_abort) begin
            bit_cnt       <= '0;
            reload_pend   <= 1'b0;
            keep_bit      <= 1'b0;
            underrun_pend <= 1'b0;
            miso_r        <= 1'b0;
            oe_r          <= 1'b0;
         end

         // With cpha=1 the first drive edge must re-present bit 0, not advance.
         if (do_load) begin
            tx_sr         <= load_word;
            miso_r        <= first_bit(load_word);
            oe_r          <= 1'b1;
            underrun_r    <= ~hold_valid;
            bit_cnt       <= '0;
            reload_pend   <= 1'b0;
            underrun_pend <= 1'b0;
            keep_bit      <= bus.cpha;
         end

         if (do_sample) begin
            rx_sr <= rx_next;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt     <= '0;
               rx_data_r   <= rx_next;
               rx_valid_r  <= 1'b1;
               reload_pend <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
            end
            if (underrun_pend) begin
               underrun_r    <= 1'b1;
               underrun_pend <= 1'b0;
            end
         end

         // A reload with an empty holder only counts as underrun once the
         // next word actually clocks its first sample edge.
         if (do_drive) begin
            if (reload_pend) begin
               tx_sr         <= load_word;
               miso_r        <= first_bit(load_word);
               underrun_pend <= ~hold_valid;
               reload_pend   <= 1'b0;
            end else if (keep_bit) begin
               keep_bit <= 1'b0;
            end else begin
               tx_sr  <= tx_adv;
               miso_r <= first_bit(tx_adv);
            end
         end
      end
   end

   assign bus.tx_ready    = ~hold_valid;
   assign bus.busy        = (state != IDLE);
   assign bus.rx_data     = rx_data_r;
   assign bus.rx_valid    = rx_valid_r;
   assign bus.tx_underrun = underrun_r;
   assign bus.miso_pin    = miso_r;
   assign bus.miso_oe     = oe_r;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an SPI master model drives two instances (MSB-first and
// LSB-first) and checks received/transmitted words against a word-level model.
`timescale 1ns/1ps
module tb_spi_slave;
   localparam int W = 8;
   localparam int H = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         cpol = 1'b0, cpha = 1'b0;
   logic         sclk = 1'b0, ncs = 1'b1, mosi = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         tx_valid = 1'b0;

   spi_slave_if #(.DATA_WIDTH(W)) ifa ();
   spi_slave_if #(.DATA_WIDTH(W)) ifb ();

   assign ifa.cpol = cpol;       assign ifb.cpol = cpol;
   assign ifa.cpha = cpha;       assign ifb.cpha = cpha;
   assign ifa.sclk_pin = sclk;   assign ifb.sclk_pin = sclk;
   assign ifa.ncs_pin = ncs;     assign ifb.ncs_pin = ncs;
   assign ifa.mosi_pin = mosi;   assign ifb.mosi_pin = mosi;
   assign ifa.tx_data = tx_data; assign ifb.tx_data = tx_data;
   assign ifa.tx_valid = tx_valid; assign ifb.tx_valid = tx_valid;

   spi_slave #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   spi_slave #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

   int checks = 0;
   int errors = 0;

   logic [W-1:0] rxq_a[$], rxq_b[$];
   int           und_a = 0, und_b = 0;
   logic         send_q[$], got_a[$], got_b[$];
   int           stable_err, busy_err, oe_err;

   always @(negedge clk) begin
      if (ifa.rx_valid === 1'b1) rxq_a.push_back(ifa.rx_data);
      if (ifb.rx_valid === 1'b1) rxq_b.push_back(ifb.rx_data);
      if (ifa.tx_underrun === 1'b1) und_a++;
      if (ifb.tx_underrun === 1'b1) und_b++;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog simulation did not finish, required finish before 900us");
      $fatal(1);
   end

   function automatic void push_word(input logic [W-1:0] w, input bit msb);
      for (int i = 0; i < W; i++) send_q.push_back(msb ? w[W-1-i] : w[i]);
   endfunction

   function automatic logic [W-1:0] rev(input logic [W-1:0] w);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = w[W-1-i];
      return r;
   endfunction

   // Master-side view of MISO: word k as seen by an MSB-first / LSB-first reader.
   function automatic logic [W-1:0] read_a(input int k);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) w[W-1-i] = got_a[k*W+i];
      return w;
   endfunction

   function automatic logic [W-1:0] read_b(input int k);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) w[i] = got_b[k*W+i];
      return w;
   endfunction

   task automatic set_mode(input logic [1:0] md);
      cpol = md[1];
      cpha = md[0];
      sclk = md[1];
      repeat (4) @(negedge clk);
   endtask

   task automatic feed(input logic [W-1:0] w);
      int n = 0;
      tx_data  = w;
      tx_valid = 1'b1;
      while (ifa.tx_ready !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      checks++;
      if (n >= 4000) begin
         errors++;
         $display("FAIL feed_timeout tx_ready=%b required 1", ifa.tx_ready);
      end
   endtask

   task automatic xfer_begin();
      got_a.delete();
      got_b.delete();
      stable_err = 0;
      busy_err   = 0;
      oe_err     = 0;
      ncs = 1'b0;
      repeat (H) @(negedge clk);
   endtask

   task automatic xfer_bits(input int n);
      logic b, pre_a, pre_b;
      for (int i = 0; i < n; i++) begin
         b = send_q.pop_front();
         if (!cpha) mosi = b;
         else begin
            sclk = ~cpol;
            mosi = b;
         end
         repeat (H) @(negedge clk);
         pre_a = ifa.miso_pin;
         pre_b = ifb.miso_pin;
         if (ifa.busy !== 1'b1) busy_err++;
         if (ifa.miso_oe !== 1'b1) oe_err++;
         sclk = cpha ? cpol : ~cpol;
         repeat (H) @(negedge clk);
         if (ifa.miso_pin !== pre_a || ifb.miso_pin !== pre_b) stable_err++;
         if (!cpha) sclk = cpol;
         got_a.push_back(pre_a);
         got_b.push_back(pre_b);
      end
   endtask

   task automatic xfer_end();
      repeat (H) @(negedge clk);
      ncs = 1'b1;
      sclk = cpol;
      repeat (2*H) @(negedge clk);
   endtask

   task automatic run_xfer(input int nbits);
      xfer_begin();
      xfer_bits(nbits);
      xfer_end();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ifa.tx_ready, ifa.rx_valid, ifa.tx_underrun, ifa.busy, ifa.miso_pin, ifa.miso_oe} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags got=%b required 100000",
                  {ifa.tx_ready, ifa.rx_valid, ifa.tx_underrun, ifa.busy, ifa.miso_pin, ifa.miso_oe});
      end
      checks++;
      if (ifa.rx_data !== '0 || ifb.rx_data !== '0) begin
         errors++;
         $display("FAIL reset_rx_data got=%h/%h required 00", ifa.rx_data, ifb.rx_data);
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_modes();
      logic [W-1:0] t, m;
      for (int r = 0; r < 2; r++) begin
         for (int md = 0; md < 4; md++) begin
            t = (r == 0) ? 8'hA5 : W'($urandom);
            m = (r == 0) ? 8'h3C : W'($urandom);
            set_mode(md[1:0]);
            rxq_a.delete(); rxq_b.delete(); und_a = 0;
            feed(t);
            checks++;
            if (ifa.tx_ready !== 1'b0) begin
               errors++;
               $display("FAIL mode%0d held_ready got=%b required 0", md, ifa.tx_ready);
            end
            push_word(m, 1'b1);
            run_xfer(W);
            checks++;
            if (read_a(0) !== t) begin
               errors++;
               $display("FAIL mode%0d miso_word got=%h required %h", md, read_a(0), t);
            end
            checks++;
            if (rxq_a.size() != 1 || rxq_a[0] !== m) begin
               errors++;
               $display("FAIL mode%0d rx_word pulses=%0d got=%h required 1 pulse %h",
                        md, rxq_a.size(), ifa.rx_data, m);
            end
            checks++;
            if (rxq_b.size() != 1 || rxq_b[0] !== rev(m) || read_b(0) !== t) begin
               errors++;
               $display("FAIL mode%0d lsb_inst rx=%h miso=%h required rx=%h miso=%h",
                        md, ifb.rx_data, read_b(0), rev(m), t);
            end
            checks++;
            if (stable_err != 0 || busy_err != 0 || oe_err != 0) begin
               errors++;
               $display("FAIL mode%0d miso_timing stable=%0d busy=%0d oe=%0d required 0 0 0",
                        md, stable_err, busy_err, oe_err);
            end
            checks++;
            if ({ifa.tx_ready, ifa.miso_oe, ifa.busy, und_a != 0} !== 4'b1000) begin
               errors++;
               $display("FAIL mode%0d after_xfer ready/oe/busy/und got=%b required 1000",
                        md, {ifa.tx_ready, ifa.miso_oe, ifa.busy, und_a != 0});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] tw[3], mw[3];
      for (int p = 0; p < 2; p++) begin
         set_mode(p == 0 ? 2'd0 : 2'd3);
         for (int k = 0; k < 3; k++) begin
            tw[k] = (p == 0) ? W'(8'h11 * (k + 1)) : W'($urandom);
            mw[k] = (p == 0) ? W'(k + 1) : W'($urandom);
         end
         rxq_a.delete(); rxq_b.delete(); und_a = 0;
         feed(tw[0]);
         for (int k = 0; k < 3; k++) push_word(mw[k], 1'b1);
         fork
            run_xfer(3*W);
            begin
               feed(tw[1]);
               feed(tw[2]);
            end
         join
         checks++;
         if (rxq_a.size() != 3) begin
            errors++;
            $display("FAIL b2b%0d rx_pulses got=%0d required 3", p, rxq_a.size());
         end else begin
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (rxq_a[k] !== mw[k] || read_a(k) !== tw[k]) begin
                  errors++;
                  $display("FAIL b2b%0d word%0d rx=%h miso=%h required rx=%h miso=%h",
                           p, k, rxq_a[k], read_a(k), mw[k], tw[k]);
               end
            end
         end
         checks++;
         if (und_a != 0 || stable_err != 0) begin
            errors++;
            $display("FAIL b2b%0d underrun=%0d stable=%0d required 0 0", p, und_a, stable_err);
         end
      end
   endtask

   task automatic test_underrun();
      logic [W-1:0] m;
      m = W'($urandom);
      set_mode(2'($urandom_range(0, 3)));
      rxq_a.delete(); und_a = 0; und_b = 0;
      checks++;
      if (ifa.tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL underrun_pre tx_ready=%b required 1", ifa.tx_ready);
      end
      push_word(m, 1'b1);
      run_xfer(W);
      checks++;
      if (und_a != 1 || und_b != 1) begin
         errors++;
         $display("FAIL underrun_pulses got=%0d/%0d required 1", und_a, und_b);
      end
      checks++;
      if (read_a(0) !== '0 || rxq_a.size() != 1 || rxq_a[0] !== m) begin
         errors++;
         $display("FAIL underrun_data miso=%h rx=%h required miso=00 rx=%h", read_a(0), ifa.rx_data, m);
      end
   endtask

   task automatic test_lsb_first();
      logic [W-1:0] t, m;
      for (int r = 0; r < 2; r++) begin
         t = W'($urandom);
         m = (r == 0) ? 8'h01 : W'($urandom);
         set_mode(r == 0 ? 2'd0 : 2'd2);
         rxq_a.delete(); rxq_b.delete();
         feed(t);
         push_word(m, 1'b0);
         run_xfer(W);
         checks++;
         if (rxq_b.size() != 1 || rxq_b[0] !== m || read_b(0) !== t) begin
            errors++;
            $display("FAIL lsb%0d rx=%h miso=%h required rx=%h miso=%h", r, ifb.rx_data, read_b(0), m, t);
         end
         checks++;
         if (rxq_a.size() != 1 || rxq_a[0] !== rev(m)) begin
            errors++;
            $display("FAIL lsb%0d msb_inst_rx got=%h required %h", r, ifa.rx_data, rev(m));
         end
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] t, m;
      int ready_seen = 0;
      t = W'($urandom);
      m = W'($urandom);
      set_mode(2'd1);
      rxq_a.delete();
      feed(t);
      tx_data  = ~t;
      tx_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (ifa.tx_ready !== 1'b0) ready_seen++;
      end
      tx_valid = 1'b0;
      checks++;
      if (ready_seen != 0) begin
         errors++;
         $display("FAIL hold_ready cycles_ready=%0d required 0", ready_seen);
      end
      push_word(m, 1'b1);
      run_xfer(W);
      checks++;
      if (read_a(0) !== t || rxq_a.size() != 1 || rxq_a[0] !== m) begin
         errors++;
         $display("FAIL hold_word miso=%h rx=%h required miso=%h rx=%h", read_a(0), ifa.rx_data, t, m);
      end
   endtask

   task automatic test_abort();
      logic [W-1:0] p, m;
      set_mode(2'($urandom_range(0, 3)));
      p = W'($urandom);
      feed(W'($urandom));
      push_word(p, 1'b1);
      run_xfer(W);
      rxq_a.delete();
      feed(W'($urandom));
      push_word(W'($urandom), 1'b1);
      xfer_begin();
      xfer_bits(5);
      send_q.delete();
      xfer_end();
      checks++;
      if (rxq_a.size() != 0 || ifa.rx_data !== p) begin
         errors++;
         $display("FAIL abort_rx pulses=%0d rx=%h required 0 pulses rx=%h", rxq_a.size(), ifa.rx_data, p);
      end
      checks++;
      if ({ifa.miso_oe, ifa.miso_pin, ifa.busy} !== 3'b000) begin
         errors++;
         $display("FAIL abort_pins oe/miso/busy got=%b required 000", {ifa.miso_oe, ifa.miso_pin, ifa.busy});
      end
      m = W'($urandom);
      p = W'($urandom);
      feed(p);
      push_word(m, 1'b1);
      run_xfer(W);
      checks++;
      if (rxq_a.size() != 1 || rxq_a[0] !== m || read_a(0) !== p) begin
         errors++;
         $display("FAIL abort_next rx=%h miso=%h required rx=%h miso=%h", ifa.rx_data, read_a(0), m, p);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] t, m;
      set_mode(2'd0);
      rxq_a.delete();
      feed(W'($urandom));
      push_word(W'($urandom), 1'b1);
      xfer_begin();
      xfer_bits(3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({ifa.tx_ready, ifa.rx_valid, ifa.tx_underrun, ifa.busy, ifa.miso_pin, ifa.miso_oe} !== 6'b100000
          || ifa.rx_data !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs flags=%b rx=%h required 100000 rx=00",
                  {ifa.tx_ready, ifa.rx_valid, ifa.tx_underrun, ifa.busy, ifa.miso_pin, ifa.miso_oe}, ifa.rx_data);
      end
      xfer_bits(W - 3);
      checks++;
      if (rxq_a.size() != 0 || ifa.busy !== 1'b0 || ifa.miso_oe !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_ignored pulses=%0d busy=%b oe=%b required 0 0 0",
                  rxq_a.size(), ifa.busy, ifa.miso_oe);
      end
      xfer_end();
      t = W'($urandom);
      m = W'($urandom);
      feed(t);
      push_word(m, 1'b1);
      run_xfer(W);
      checks++;
      if (rxq_a.size() != 1 || rxq_a[0] !== m || read_a(0) !== t) begin
         errors++;
         $display("FAIL rst_mid_next rx=%h miso=%h required rx=%h miso=%h", ifa.rx_data, read_a(0), m, t);
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_back_to_back();
      test_underrun();
      test_lsb_first();
      test_hold();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
